// File: rtl/count_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_capture_pkg
// Description : Shared defaults, edge-select encodings and the default-width
//               capture entry layout for the count capture unit.
// Revision    : 1.0 - initial release
// ============================================================================
package count_capture_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_DEPTH       = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Value of edge_sel that selects which event transition is captured
    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    // One queued capture: counter stamp, interval to previous capture, and
    // a flag marking the first capture since reset or re-enable.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] stamp;
        logic [DEFAULT_WIDTH-1:0] period;
        logic                     first;
    } capture_entry_t;

endpackage
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : capture_fifo
// Description : DEPTH-entry register FIFO of capture entries. Head is read
//               directly from storage (no bypass); a push is accepted while
//               full when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_fifo
    import count_capture_pkg::*;
#(
    parameter type entry_t = capture_entry_t,
    parameter int  DEPTH   = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    entry_t          r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign level     = r_wr_ptr - r_rd_ptr;
    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_capture_unit.sv
`default_nettype none
// ============================================================================
// Module      : count_capture_unit
// Description : Synchronizes an asynchronous event pin, latches the
//               free-running counter on the selected edge, computes the
//               interval since the previous capture and queues the result
//               for a valid/ready consumer. Sticky overflow on dropped events.
// Revision    : 1.0 - initial release
// ============================================================================
module count_capture_unit
    import count_capture_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       count,
    input  logic                   event_pin,
    input  logic                   edge_sel,
    input  logic                   enable,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_stamp,
    output logic [WIDTH-1:0]       rd_period,
    output logic                   rd_first,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    typedef struct packed {
        logic [WIDTH-1:0] stamp;
        logic [WIDTH-1:0] period;
        logic             first;
    } entry_t;

    // Reset-zero synchronizer flops must flush before an edge can be trusted
    localparam int WARM_CYCLES = SYNC_STAGES + 1;
    localparam int WW          = $clog2(WARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [WW-1:0]          r_warm_cnt;
    logic                   w_warm_done;
    logic                   w_sync_now;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge_hit;
    logic                   w_capture;
    logic [WIDTH-1:0]       r_last_stamp;
    logic                   r_have_last;
    logic                   r_overflow;
    entry_t                 w_new_entry;
    entry_t                 w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_drop;

    // Event synchronizer chain followed by the previous-value flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], event_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Warm-up counter saturates once the synchronizer holds only real pin samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm_cnt <= '0;
        end else if (!w_warm_done) begin
            r_warm_cnt <= r_warm_cnt + 1'b1;
        end
    end

    assign w_warm_done = (r_warm_cnt == WW'(WARM_CYCLES));
    assign w_sync_now  = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_sync_now & ~r_prev;
    assign w_fall      = ~w_sync_now & r_prev;
    assign w_edge_hit  = (edge_sel == EDGE_RISE) ? w_rise : w_fall;
    assign w_capture   = w_edge_hit && enable && w_warm_done;

    // Assemble the entry from the counter value present at the capture edge
    always_comb begin
        w_new_entry        = '0;
        w_new_entry.stamp  = count;
        w_new_entry.period = r_have_last ? (count - r_last_stamp) : '0;
        w_new_entry.first  = !r_have_last;
    end

    assign w_pop  = rd_valid && rd_ready;
    assign w_drop = w_capture && w_full && !w_pop;

    // Previous-stamp tracking; advances even when the entry itself is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_stamp <= '0;
            r_have_last  <= 1'b0;
        end else if (w_capture) begin
            r_last_stamp <= count;
            r_have_last  <= 1'b1;
        end else if (!enable) begin
            r_have_last  <= 1'b0;
        end
    end

    // Sticky overflow; a new drop takes priority over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    capture_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_capture),
        .push_data (w_new_entry),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level)
    );

    assign rd_valid  = !w_empty;
    assign rd_stamp  = w_head.stamp;
    assign rd_period = w_head.period;
    assign rd_first  = w_head.first;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_count_capture_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_capture_unit
// Description : Randomized and directed bench for count_capture_unit with an
//               event-schedule reference model and a queue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_capture_unit;
    import count_capture_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] count;
    logic        event_pin;
    logic        edge_sel;
    logic        enable;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_stamp;
    logic [31:0] rd_period;
    logic        rd_first;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_ovf;

    int n_cmp = 0;
    int n_err = 0;

    count_capture_unit #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count),
        .event_pin (event_pin),
        .edge_sel  (edge_sel),
        .enable    (enable),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_stamp  (rd_stamp),
        .rd_period (rd_period),
        .rd_first  (rd_first),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] stamp;
        logic [31:0] period;
        logic        first;
    } exp_t;

    typedef struct {
        int   due;
        logic pol;
    } tr_t;

    exp_t        sb[$];
    tr_t         pending[$];
    int          edge_idx;
    logic        prev_pin;
    int          mlevel;
    logic        movf;
    logic        have_last;
    logic [31:0] last_stamp;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        pending.delete();
        edge_idx   = 0;
        prev_pin   = 1'b0;
        mlevel     = 0;
        movf       = 1'b0;
        have_last  = 1'b0;
        last_stamp = '0;
    endtask

    // Model rules: a pin change seen at edge e is acted on at edge e+SYNC,
    // nothing is captured in the first SYNC+1 edges after reset release,
    // and the FIFO is a DEPTH-limited queue with pop-before-push semantics.
    task automatic model_edge();
        tr_t         t;
        exp_t        e;
        logic        cap;
        logic        pop;
        logic        set_ovf;
        if (!rst_n) return;
        edge_idx++;
        if (event_pin !== prev_pin) begin
            t.due = edge_idx + SYNC;
            t.pol = event_pin;
            pending.push_back(t);
            prev_pin = event_pin;
        end
        cap = 1'b0;
        if (pending.size() > 0 && pending[0].due == edge_idx) begin
            t = pending.pop_front();
            if (edge_idx > SYNC + 1 && enable && (t.pol != edge_sel)) cap = 1'b1;
        end
        pop     = (mlevel > 0) && rd_ready;
        set_ovf = 1'b0;
        if (cap) begin
            e.stamp  = count;
            e.first  = !have_last;
            e.period = have_last ? (count - last_stamp) : 32'd0;
            last_stamp = count;
            have_last  = 1'b1;
            if (mlevel < DEPTH || pop) begin
                sb.push_back(e);
                mlevel++;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (!enable) begin
            have_last = 1'b0;
        end
        if (pop) mlevel--;
        if (set_ovf) movf = 1'b1;
        else if (clr_ovf) movf = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_valid", rd_valid, (mlevel != 0));
            check("level", level, mlevel);
            check("overflow", overflow, movf);
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check("head_present", 0, 1);
                end else begin
                    check("head_stamp", rd_stamp, sb[0].stamp);
                    check("head_period", rd_period, sb[0].period);
                    check("head_first", rd_first, sb[0].first);
                    if (rd_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        count = count + 1;
    endtask

    task automatic pulse(input int hi, input int lo);
        event_pin = 1'b1;
        repeat (hi) tick();
        event_pin = 1'b0;
        repeat (lo) tick();
    endtask

    logic ready_mode;

    initial begin
        rst_n = 1'b0; event_pin = 1'b0; edge_sel = 1'b0; enable = 1'b1;
        rd_ready = 1'b1; clr_ovf = 1'b0; count = '0;
        model_reset();
        #2;
        check("rst_valid", rd_valid, 0);
        check("rst_stamp", rd_stamp, 0);
        check("rst_period", rd_period, 0);
        check("rst_first", rd_first, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        #30 rst_n = 1'b1;
        repeat (6) tick();

        // Regular rising edges 10 cycles apart, consumer always ready
        repeat (3) pulse(5, 5);
        repeat (4) tick();

        // Counter wrap between two captures
        enable = 1'b0; tick(); tick(); enable = 1'b1;
        rd_ready = 1'b0;
        event_pin = 1'b1; count = 32'hFFFF_FFF8;
        repeat (5) tick();
        event_pin = 1'b0; repeat (5) tick();
        pulse(5, 5);
        check("wrap_stamp0", rd_stamp, 32'hFFFF_FFFA);
        check("wrap_first0", rd_first, 1);
        check("wrap_period0", rd_period, 0);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        check("wrap_stamp1", rd_stamp, 32'h0000_0004);
        check("wrap_period1", rd_period, 32'h0000_000A);
        check("wrap_first1", rd_first, 0);
        rd_ready = 1'b1; repeat (4) tick();

        // Overflow: five events into a four-deep FIFO with no consumer
        rd_ready = 1'b0;
        repeat (5) pulse(4, 4);
        check("ovf_level", level, 4);
        check("ovf_set", overflow, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 20 && level != 0; i++) tick();
        check("drain_level", level, 0);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("ovf_clr", overflow, 0);
        pulse(4, 6);

        // Full FIFO with a pop on the capture edge
        rd_ready = 1'b0;
        repeat (4) pulse(4, 4);
        check("full_level", level, 4);
        event_pin = 1'b1; tick(); tick();
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        check("full_pop_level", level, 4);
        check("full_pop_ovf", overflow, 0);
        event_pin = 1'b0; repeat (4) tick();
        rd_ready = 1'b1; repeat (8) tick();

        // Falling-edge capture and enable toggle
        edge_sel = EDGE_FALL; repeat (2) tick();
        pulse(3, 6);
        enable = 1'b0; repeat (3) tick(); enable = 1'b1; tick();
        pulse(3, 6);
        edge_sel = EDGE_RISE; repeat (2) tick();

        // Asynchronous reset with entries pending, event held high through release
        rd_ready = 1'b0;
        repeat (2) pulse(3, 3);
        check("pre_rst_level", level, 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        event_pin = 1'b1;
        #1;
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst_level", level, 0);
        event_pin = 1'b0; repeat (4) tick();

        // Randomized traffic
        rd_ready = 1'b1; ready_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) event_pin = ~event_pin;
            if ($urandom_range(0, 15) == 0) ready_mode = ~ready_mode;
            rd_ready = ready_mode ? ($urandom_range(0, 3) != 0) : 1'b0;
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 79) == 0) edge_sel = ~edge_sel;
            clr_ovf = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) count = $urandom();
            tick();
        end
        clr_ovf = 1'b0; rd_ready = 1'b1;
        repeat (20) tick();
        check("final_level", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_capture_unit.md
# count_capture_unit

Event timestamp capture block: the reader side of the free-running counter. Samples an asynchronous event pin, latches the counter value on each selected edge, computes the interval since the previous event, and queues {stamp, period, first} entries in a small FIFO. Entries are drained over a valid/ready port by the host/ALU side.

## Interface
- WIDTH, 32: width of COUNT, stamps and periods
- DEPTH, 4: FIFO entries (power of two, ≥2)
- SYNC_STAGES, 2: event synchronizer flops (≥2)

- CLK  in  1  single clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- COUNT  in  WIDTH  free-running counter value
- EVENT  in  1  asynchronous event input
- EDGE_SEL  in  1  0 = rising edge captures, 1 = falling edge captures
- ENABLE  in  1  capture enable
- RD_VALID  out  1  FIFO head valid
- RD_READY  in  1  consumer accepts head
- RD_STAMP  out  WIDTH  COUNT at capture
- RD_PERIOD  out  WIDTH  stamp minus previous stamp, mod 2^WIDTH
- RD_FIRST  out  1  no prior capture since reset/enable; RD_PERIOD = 0
- LEVEL  out  $clog2(DEPTH)+1  entries held
- OVERFLOW  out  1  sticky: event dropped because FIFO full
- CLR_OVF  in  1  clears OVERFLOW

## Operation
- EVENT passes SYNC_STAGES flops, then a prev flop; edge = sync/prev mismatch matching EDGE_SEL.
- Warm-up: detection masked for SYNC_STAGES+1 cycles after reset release (no spurious edge from reset-zero flops).
- Capture when edge && ENABLE && !warm-up: stamp = COUNT sampled that edge; period = stamp − last_stamp (modular subtraction, wrap handled naturally); first = !have_last. last_stamp <= stamp, have_last <= 1.
- ENABLE low: no captures, have_last cleared; synchronizer/prev keep tracking; FIFO contents kept.
- Push when capture && (!full || pop). Pop when RD_VALID && RD_READY. Push+pop same cycle: LEVEL unchanged, both take effect (including when full).
- Capture while full and no pop: entry dropped, OVERFLOW <= 1; last_stamp still updated (next period measured from the dropped event).
- CLR_OVF clears OVERFLOW; set and clear same cycle: set wins.
- RD_STAMP/RD_PERIOD/RD_FIRST stable while RD_VALID && !RD_READY.

## Timing
- Reset (async assert): RD_VALID 0, RD_STAMP 0, RD_PERIOD 0, RD_FIRST 0, LEVEL 0, OVERFLOW 0; FIFO empty, have_last 0, last_stamp 0, sync/prev 0, warm-up counter restarts. Takes effect immediately, mid-operation included; pending entries lost.
- Latency: EVENT transition set up before edge n → entry written at edge n+SYNC_STAGES; RD_VALID high after that edge. Stamp = COUNT at that edge (constant SYNC_STAGES offset from the true event).
- No bypass: an empty-FIFO push is not poppable in the same cycle.
- Minimum resolvable event spacing: 2 cycles (one high, one low, synchronized).
- Throughput: one push and one pop per cycle.

## Structure
- Package count_capture_pkg: default WIDTH/DEPTH, entry struct {stamp, period, first}, EDGE_RISE/EDGE_FALL constants.
- Sub-module capture_fifo: DEPTH-entry register FIFO of the entry struct, push/pop/full/empty/level, push-when-full-with-pop allowed.
- Top holds synchronizer, warm-up counter, edge detect, last_stamp/have_last, OVERFLOW.

## Test plan
- COUNT = cycle count, ENABLE=1, EDGE_SEL=0, rising edges 10 cycles apart, RD_READY=1 -> first entry RD_FIRST=1 RD_PERIOD=0; next two RD_PERIOD=0x0000000A, stamps differing by 10.
- COUNT preset 0xFFFFFFFA, events at COUNT 0xFFFFFFFA and 0x00000004 -> second RD_PERIOD=0x0000000A.
- RD_READY=0, five events, DEPTH=4 -> LEVEL=4, OVERFLOW=1 after 5th; drain yields 4 entries; CLR_OVF -> OVERFLOW=0; next event's period measured from 5th event.
- Full FIFO, RD_READY=1 on capture cycle -> LEVEL stays 4, OVERFLOW stays 0, new entry at tail.
- EDGE_SEL=1, EVENT pulses high 3 cycles -> exactly one entry, stamp at falling-edge capture; ENABLE toggled low/high -> next entry RD_FIRST=1.
- Two entries queued, RESET driven low mid-cycle -> RD_VALID, LEVEL, OVERFLOW 0 immediately; EVENT held high through release -> no capture.
